// File: rtl/ext_arbiter.sv
// ext_arbiter
//   Shares one 16-to-32-bit extension/shift unit between two requesters:
//   port 0 (decode immediate path) and port 1 (load-data path for lb/lbu/lh/lhu).
//   Arbitrates with valid/ready, registers the extended result and presents it
//   on one output channel tagged with the source port.
//
// Parameters
//   RR_EN     1 = round-robin between the ports, 0 = fixed priority (port 0 wins)
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   r0_valid/mode/data/ready  port 0 request channel
//   r1_valid/mode/data/ready  port 1 request channel
//   o_valid/data/src/err      registered result channel
//   o_ready                   consumer accepts the result
//
// Mode encoding (d = operand)
//   000 sign16  001 zero16  010 lui  011 branch (sign16 << 2)
//   100 sign8   101 zero8   110/111 illegal -> 32'h0 with o_err set
module ext_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        r0_valid,
    input  logic [2:0]  r0_mode,
    input  logic [15:0] r0_data,
    output logic        r0_ready,

    input  logic        r1_valid,
    input  logic [2:0]  r1_mode,
    input  logic [15:0] r1_data,
    output logic        r1_ready,

    output logic        o_valid,
    output logic [31:0] o_data,
    output logic        o_src,
    output logic        o_err,
    input  logic        o_ready
);

    // Extension modes
    localparam logic [2:0] ModeSign16 = 3'b000;
    localparam logic [2:0] ModeZero16 = 3'b001;
    localparam logic [2:0] ModeLui    = 3'b010;
    localparam logic [2:0] ModeBranch = 3'b011;
    localparam logic [2:0] ModeSign8  = 3'b100;
    localparam logic [2:0] ModeZero8  = 3'b101;

    // Output register and arbitration pointer
    logic        r_valid;
    logic [31:0] r_data;
    logic        r_src;
    logic        r_err;
    logic        r_last_grant;

    // Combinational arbitration / datapath
    logic        w_can_accept;
    logic        w_any_valid;
    logic        w_grant;
    logic        w_accept;
    logic [2:0]  w_sel_mode;
    logic [15:0] w_sel_data;
    logic [31:0] w_ext_data;
    logic        w_ext_err;

    // Output register is free when empty or being drained this cycle.
    assign w_can_accept = !r_valid || o_ready;
    assign w_any_valid  = r0_valid || r1_valid;

    // Grant selection. With both ports valid, round-robin picks the port that
    // did not win last time; fixed priority always picks port 0.
    always_comb begin
        w_grant = 1'b0;
        if (r0_valid && r1_valid) begin
            if (RR_EN) begin
                w_grant = ~r_last_grant;
            end else begin
                w_grant = 1'b0;
            end
        end else if (r1_valid) begin
            w_grant = 1'b1;
        end else begin
            w_grant = 1'b0;
        end
    end

    assign r0_ready = w_can_accept && w_any_valid && (w_grant == 1'b0);
    assign r1_ready = w_can_accept && w_any_valid && (w_grant == 1'b1);
    assign w_accept = r0_ready || r1_ready;

    // Operand mux for the shared extension unit
    always_comb begin
        w_sel_mode = r0_mode;
        w_sel_data = r0_data;
        if (w_grant) begin
            w_sel_mode = r1_mode;
            w_sel_data = r1_data;
        end
    end

    // Shared extension/shift unit
    always_comb begin
        w_ext_data = 32'h0;
        w_ext_err  = 1'b0;
        case (w_sel_mode)
            ModeSign16: w_ext_data = {{16{w_sel_data[15]}}, w_sel_data};
            ModeZero16: w_ext_data = {16'b0, w_sel_data};
            ModeLui:    w_ext_data = {w_sel_data, 16'b0};
            ModeBranch: w_ext_data = {{14{w_sel_data[15]}}, w_sel_data, 2'b00};
            ModeSign8:  w_ext_data = {{24{w_sel_data[7]}}, w_sel_data[7:0]};
            ModeZero8:  w_ext_data = {24'b0, w_sel_data[7:0]};
            default: begin
                w_ext_data = 32'h0;
                w_ext_err  = 1'b1;
            end
        endcase
    end

    // Output register. An accept in the same cycle as a consume simply
    // overwrites the old result, giving one result per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_data       <= 32'h0;
            r_src        <= 1'b0;
            r_err        <= 1'b0;
            r_last_grant <= 1'b1;  // port 0 wins the first contest
        end else if (w_accept) begin
            r_valid      <= 1'b1;
            r_data       <= w_ext_data;
            r_src        <= w_grant;
            r_err        <= w_ext_err;
            r_last_grant <= w_grant;
        end else if (o_ready) begin
            // Consumed with nothing new: drop valid, keep the payload.
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_src   = r_src;
    assign o_err   = r_err;

endmodule

// File: doc/ext_arbiter.md
Name: ext_arbiter

Overview:
- Shares one 16-to-32-bit extension/shift unit between two requesters: port 0 is the decode-stage immediate path and port 1 is the load-data path for lb, lbu, lh and lhu.
- Arbitrates between the ports with valid/ready handshakes and registers the extended result.
- Presents the result on a single output channel with a source tag.
- Sits between decode/MEM and the ALU operand and writeback muxes of the multicycle CPU.

Parameters:
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, port 0 always wins.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- r0_valid  input  1  port 0 request valid.
- r0_mode  input  3  port 0 extension mode.
- r0_data  input  16  port 0 operand.
- r0_ready  output  1  port 0 request accepted this cycle.
- r1_valid  input  1  port 1 request valid.
- r1_mode  input  3  port 1 extension mode.
- r1_data  input  16  port 1 operand.
- r1_ready  output  1  port 1 request accepted this cycle.
- o_valid  output  1  result valid.
- o_data  output  32  extended result.
- o_src  output  1  port that produced the result (0/1).
- o_err  output  1  result came from an illegal mode.
- o_ready  input  1  consumer accepts the result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: o_valid=0, o_data=0, o_src=0, o_err=0, last_grant=1, so port 0 wins the first contest. Asserting rst mid-operation discards any pending result with no handshake.
- Modes, applied to d=data:
  - 000 sign16 = {16{d[15]},d}
  - 001 zero16 = {16'b0,d}
  - 010 lui = {d,16'b0}
  - 011 branch = {14{d[15]},d,2'b00}
  - 100 sign8 = {24{d[7]},d[7:0]}
  - 101 zero8 = {24'b0,d[7:0]}
  - 110/111 illegal: result 32'h0 and o_err=1.
- Output register empty condition: can_accept = !o_valid || o_ready.
- Grant logic, combinational:
  - Only one port valid → that port is granted.
  - Both valid, RR_EN=1 → grant port != last_grant.
  - Both valid, RR_EN=0 → grant port 0.
  - rX_ready = can_accept && grant==X. At most one ready is high per cycle.
  - No valid requests → both readies low.
- Accept (rX_valid && rX_ready at edge N):
  - o_data, o_src and o_err load from that port.
  - o_valid=1 from cycle N+1. Latency is 1 cycle.
  - last_grant is updated to X. last_grant changes only on an accept.
- Consume: o_valid && o_ready with no new accept in the same cycle → o_valid=0 next cycle, and o_data holds its last value.
- Back-to-back: consume and accept in the same cycle → the new result replaces the old one. Sustained throughput is 1 result/cycle.
- Backpressure: o_valid && !o_ready → o_data, o_src, o_err are held stable; both readies are 0.
- Requester protocol: a requester holds valid, mode and data stable until ready. A requester that drops valid before ready is not serviced. A change to mode or data while unaccepted is legal; the value sampled at accept is used.
- Starvation: with RR_EN=1 a waiting port is granted within 2 accepts. With RR_EN=0, port 1 may starve (intended).
- There is no internal FSM beyond the output-valid bit and the last_grant pointer.

Test Plan:
1. Reset/single request: hold rst 2 cycles → all outputs 0. Then r0_valid=1, mode=000, data=16'h8001, o_ready=1 → r0_ready=1 that cycle; next cycle o_valid=1, o_data=32'hFFFF8001, o_src=0, o_err=0.
2. Mode sweep on port 1 with data=16'h80F4:
   - sign16 → FFFF80F4; zero16 → 000080F4; lui → 80F40000
   - branch → FFFE03D0; sign8 → FFFFFFF4; zero8 → 000000F4
   - mode 111 → 00000000 with o_err=1.
3. Contention, RR_EN=1: both ports valid continuously, o_ready=1 → o_src sequence 0,1,0,1 on consecutive cycles; exactly one rX_ready per cycle.
4. Backpressure: result pending, o_ready=0 for 3 cycles while r0 and r1 are both valid → o_data/o_src stable, r0_ready=r1_ready=0. o_ready=1 → next result appears the following cycle with no bubble.
5. Fixed priority, RR_EN=0: both ports valid for 5 cycles → o_src=0 for all 5. Drop r0_valid → port 1 granted next cycle.
6. Reset mid-operation: o_valid=1 held by o_ready=0, assert rst → o_valid=0, o_data=0 next cycle. After release, first contest goes to port 0.
